riscv_mem_sched: RTL and testbench

//  Round-robin scheduler that shares the single memory request port between the I$ and D$ refill paths.

---
 rtl/riscv_mem_sched_pkg.sv | 28 ++
 rtl/riscv_mem_sched_tracker.sv | 70 +++++++
 rtl/riscv_mem_sched.sv | 165 ++++++++++++++++
 tb/tb_riscv_mem_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_sched_pkg.sv
// Shared definitions for the memory request scheduler: widths, tag port
// encodings, scheduler state encoding and the tag builder.
package riscv_mem_sched_pkg;

    localparam int MEM_ADDR_BITS = 32;
    localparam int MEM_SEQ_BITS  = 3;
    localparam int MEM_TAG_BITS  = MEM_SEQ_BITS + 1;
    localparam int CNT_BITS      = 3;

    localparam logic MEM_TAG_PORT_IC = 1'b0;
    localparam logic MEM_TAG_PORT_DC = 1'b1;

    typedef enum logic [1:0] {
        SCHED_IDLE    = 2'd0,
        SCHED_LOCK_IC = 2'd1,
        SCHED_LOCK_DC = 2'd2
    } sched_state_e;

    // Tag layout is {sequence, port}; port sits in bit 0 so responses can be
    // routed by a single bit.
    function automatic logic [MEM_TAG_BITS-1:0] make_tag(
        input logic [MEM_SEQ_BITS-1:0] seq,
        input logic                    port
    );
        return {seq, port};
    endfunction

endpackage

// File: rtl/riscv_mem_sched_tracker.sv
// Per-port bookkeeping: in-flight counter, issue/expect sequence numbers,
// credit check and response ordering check.
module riscv_mem_port_tracker
    import riscv_mem_sched_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept_i,
    input  logic                    resp_hit_i,
    input  logic [MEM_SEQ_BITS-1:0] resp_seq_i,
    output logic                    credit_ok_o,
    output logic                    resp_fwd_o,
    output logic                    err_o,
    output logic [MEM_SEQ_BITS-1:0] iss_seq_o,
    output logic [CNT_BITS-1:0]     outstanding_o
);

    logic [CNT_BITS-1:0]     out_q, out_d;
    logic [MEM_SEQ_BITS-1:0] iss_q, iss_d;
    logic [MEM_SEQ_BITS-1:0] exp_q, exp_d;
    logic                    resp_ok_s;

    // Credit/ordering decode and next-state for counter and sequence numbers.
    always_comb begin
        credit_ok_o = (out_q < CNT_BITS'(MAX_OUT));
        // A response with nothing in flight cannot belong to this port.
        resp_ok_s   = resp_hit_i && (out_q != {CNT_BITS{1'b0}});
        resp_fwd_o  = resp_ok_s;
        err_o       = resp_hit_i && (!resp_ok_s || (resp_seq_i != exp_q));

        if (accept_i && !resp_ok_s) begin
            out_d = out_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else if (!accept_i && resp_ok_s) begin
            out_d = out_q - {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            out_d = out_q;
        end

        if (accept_i) begin
            iss_d = iss_q + {{(MEM_SEQ_BITS-1){1'b0}}, 1'b1};
        end else begin
            iss_d = iss_q;
        end

        if (resp_ok_s) begin
            exp_d = exp_q + {{(MEM_SEQ_BITS-1){1'b0}}, 1'b1};
        end else begin
            exp_d = exp_q;
        end
    end

    // Counter and sequence state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= {CNT_BITS{1'b0}};
            iss_q <= {MEM_SEQ_BITS{1'b0}};
            exp_q <= {MEM_SEQ_BITS{1'b0}};
        end else begin
            out_q <= out_d;
            iss_q <= iss_d;
            exp_q <= exp_d;
        end
    end

    assign iss_seq_o     = iss_q;
    assign outstanding_o = out_q;

endmodule

// File: rtl/riscv_mem_sched.sv
// Round-robin arbiter sharing one memory request port between the I$ and D$
// refill paths, with grant locking, per-port credits and tag-based routing.
module riscv_mem_sched
    import riscv_mem_sched_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ic_mem_req_valid,
    output logic                     ic_mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr,
    output logic                     ic_mem_resp_valid,
    input  logic                     dc_mem_req_valid,
    output logic                     dc_mem_req_ready,
    input  logic                     dc_mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr,
    output logic                     dc_mem_resp_valid,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic [MEM_TAG_BITS-1:0]  mem_req_tag,
    input  logic                     mem_resp_valid,
    input  logic [MEM_TAG_BITS-1:0]  mem_resp_tag,
    output logic [CNT_BITS-1:0]      ic_outstanding,
    output logic [CNT_BITS-1:0]      dc_outstanding,
    output logic                     tag_err
);

    sched_state_e state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         tag_err_q, tag_err_d;

    logic gnt_raw_s, gnt_valid_s, gnt_port_s, viol_raw_s, viol_s, accept_s;
    logic ic_elig_s, dc_elig_s, ic_credit_s, dc_credit_s;
    logic ic_hit_s, dc_hit_s, ic_fwd_s, dc_fwd_s, ic_err_s, dc_err_s;
    logic [MEM_SEQ_BITS-1:0] ic_iss_s, dc_iss_s;

    // Grant selection, lock handling and next state; everything is gated
    // by reset_n so all outputs sit at 0 while reset is held.
    always_comb begin
        state_d    = state_q;
        gnt_raw_s  = 1'b0;
        gnt_port_s = MEM_TAG_PORT_IC;
        viol_raw_s = 1'b0;
        ic_elig_s  = ic_mem_req_valid && ic_credit_s;
        dc_elig_s  = dc_mem_req_valid && dc_credit_s;

        case (state_q)
            SCHED_IDLE: begin
                if (ic_elig_s && dc_elig_s) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = ~last_grant_q;
                end else if (ic_elig_s) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = MEM_TAG_PORT_IC;
                end else if (dc_elig_s) begin
                    gnt_raw_s  = 1'b1;
                    gnt_port_s = MEM_TAG_PORT_DC;
                end else begin
                    gnt_raw_s  = 1'b0;
                end
            end
            SCHED_LOCK_IC: begin
                gnt_port_s = MEM_TAG_PORT_IC;
                if (ic_mem_req_valid) begin
                    gnt_raw_s = 1'b1;
                end else begin
                    viol_raw_s = 1'b1;
                end
            end
            SCHED_LOCK_DC: begin
                gnt_port_s = MEM_TAG_PORT_DC;
                if (dc_mem_req_valid) begin
                    gnt_raw_s = 1'b1;
                end else begin
                    viol_raw_s = 1'b1;
                end
            end
            default: begin
                gnt_raw_s = 1'b0;
            end
        endcase

        gnt_valid_s = gnt_raw_s && reset_n;
        viol_s      = viol_raw_s && reset_n;
        accept_s    = gnt_valid_s && mem_req_ready;

        // An un-accepted grant locks onto its port; a violation or an
        // accept returns to arbitration.
        if (accept_s) begin
            state_d = SCHED_IDLE;
        end else if (gnt_valid_s) begin
            state_d = (gnt_port_s == MEM_TAG_PORT_DC) ? SCHED_LOCK_DC : SCHED_LOCK_IC;
        end else begin
            state_d = SCHED_IDLE;
        end

        last_grant_d = accept_s ? gnt_port_s : last_grant_q;
        tag_err_d    = tag_err_q | viol_s | ic_err_s | dc_err_s;
    end

    // Request-side muxes and response routing by tag port bit.
    always_comb begin
        mem_req_valid    = gnt_valid_s;
        mem_req_rw       = gnt_valid_s && (gnt_port_s == MEM_TAG_PORT_DC) && dc_mem_req_rw;
        mem_req_addr     = {MEM_ADDR_BITS{1'b0}};
        mem_req_tag      = {MEM_TAG_BITS{1'b0}};
        if (gnt_valid_s) begin
            mem_req_addr = (gnt_port_s == MEM_TAG_PORT_DC) ? dc_mem_req_addr : ic_mem_req_addr;
            mem_req_tag  = make_tag((gnt_port_s == MEM_TAG_PORT_DC) ? dc_iss_s : ic_iss_s, gnt_port_s);
        end else begin
            mem_req_addr = {MEM_ADDR_BITS{1'b0}};
        end
        ic_mem_req_ready  = accept_s && (gnt_port_s == MEM_TAG_PORT_IC);
        dc_mem_req_ready  = accept_s && (gnt_port_s == MEM_TAG_PORT_DC);
        ic_hit_s          = reset_n && mem_resp_valid && (mem_resp_tag[0] == MEM_TAG_PORT_IC);
        dc_hit_s          = reset_n && mem_resp_valid && (mem_resp_tag[0] == MEM_TAG_PORT_DC);
        ic_mem_resp_valid = ic_fwd_s;
        dc_mem_resp_valid = dc_fwd_s;
    end

    // FSM state, round-robin pointer and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SCHED_IDLE;
            last_grant_q <= MEM_TAG_PORT_DC;
            tag_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tag_err_q    <= tag_err_d;
        end
    end

    riscv_mem_port_tracker #(.MAX_OUT(MAX_OUT)) u_ic_trk (
        .clk           (clk),
        .rst_n         (reset_n),
        .accept_i      (ic_mem_req_ready),
        .resp_hit_i    (ic_hit_s),
        .resp_seq_i    (mem_resp_tag[MEM_TAG_BITS-1:1]),
        .credit_ok_o   (ic_credit_s),
        .resp_fwd_o    (ic_fwd_s),
        .err_o         (ic_err_s),
        .iss_seq_o     (ic_iss_s),
        .outstanding_o (ic_outstanding)
    );

    riscv_mem_port_tracker #(.MAX_OUT(MAX_OUT)) u_dc_trk (
        .clk           (clk),
        .rst_n         (reset_n),
        .accept_i      (dc_mem_req_ready),
        .resp_hit_i    (dc_hit_s),
        .resp_seq_i    (mem_resp_tag[MEM_TAG_BITS-1:1]),
        .credit_ok_o   (dc_credit_s),
        .resp_fwd_o    (dc_fwd_s),
        .err_o         (dc_err_s),
        .iss_seq_o     (dc_iss_s),
        .outstanding_o (dc_outstanding)
    );

    assign tag_err = tag_err_q;

endmodule

// File: tb/tb_riscv_mem_sched.sv
// Bench for riscv_mem_sched: directed scenarios plus a randomized run, all
// checked every cycle against a count/sequence reference model.
module tb_riscv_mem_sched;
    import riscv_mem_sched_pkg::*;

    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ic_mem_req_valid = 1'b0, ic_mem_req_ready, ic_mem_resp_valid;
    logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr = '0;
    logic dc_mem_req_valid = 1'b0, dc_mem_req_ready, dc_mem_req_rw = 1'b0, dc_mem_resp_valid;
    logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr = '0;
    logic mem_req_valid, mem_req_ready = 1'b0, mem_req_rw;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic [MEM_TAG_BITS-1:0] mem_req_tag;
    logic mem_resp_valid = 1'b0;
    logic [MEM_TAG_BITS-1:0] mem_resp_tag = '0;
    logic [CNT_BITS-1:0] ic_outstanding, dc_outstanding;
    logic tag_err;

    int total = 0;
    int bad = 0;

    // reference model state: port 0 = I$, port 1 = D$
    int cnt[2];
    int iss[2];
    int exps[2];
    int last;
    int lk;
    bit err;
    bit acc_p[2];

    // observed values latched at the last sample point
    logic [3:0] o_tag;
    logic o_valid, o_ic_rdy, o_dc_rdy, o_ic_resp, o_dc_resp, o_err;
    logic [2:0] o_ic_out;

    logic [3:0] t1_tags[4];
    logic [3:0] t5_tags[10];

    riscv_mem_sched #(.MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
        .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_resp_valid(ic_mem_resp_valid),
        .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
        .dc_mem_req_rw(dc_mem_req_rw), .dc_mem_req_addr(dc_mem_req_addr),
        .dc_mem_resp_valid(dc_mem_resp_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .ic_outstanding(ic_outstanding), .dc_outstanding(dc_outstanding),
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            cnt[p] = 0; iss[p] = 0; exps[p] = 0;
        end
        last = 1; lk = -1; err = 1'b0;
    endtask

    function automatic bit port_valid(input int p);
        return (p == 0) ? ic_mem_req_valid : dc_mem_req_valid;
    endfunction

    function automatic logic [3:0] resp_tag_for(input int p);
        logic [2:0] s;
        s = 3'(exps[p]);
        return {s, p == 1};
    endfunction

    // One clock cycle: predict, compare at negedge, update model at posedge.
    task automatic step();
        int g, rp;
        bit viol, acc, rhit, rok, e0, e1, gp;
        logic [2:0] rs, s3;
        logic [MEM_ADDR_BITS-1:0] eaddr;
        logic [3:0] etag;
        @(negedge clk);
        if (!reset_n) model_reset();
        g = -1; viol = 1'b0;
        if (reset_n) begin
            if (lk >= 0) begin
                if (port_valid(lk)) g = lk;
                else viol = 1'b1;
            end else begin
                e0 = ic_mem_req_valid && (cnt[0] < MAX_OUT);
                e1 = dc_mem_req_valid && (cnt[1] < MAX_OUT);
                if (e0 && e1) g = (last == 0) ? 1 : 0;
                else if (e0) g = 0;
                else if (e1) g = 1;
            end
        end
        acc  = (g >= 0) && mem_req_ready;
        rp   = int'(mem_resp_tag[0]);
        rs   = mem_resp_tag[3:1];
        rhit = reset_n && mem_resp_valid;
        rok  = rhit && (cnt[rp] > 0);
        gp   = (g == 1);
        eaddr = (g == 0) ? ic_mem_req_addr : ((g == 1) ? dc_mem_req_addr : '0);
        s3   = (g >= 0) ? 3'(iss[g]) : 3'd0;
        etag = (g >= 0) ? {s3, gp} : 4'd0;

        chk("mem_req_valid", 64'(mem_req_valid), 64'(g >= 0));
        chk("ic_ready", 64'(ic_mem_req_ready), 64'(acc && g == 0));
        chk("dc_ready", 64'(dc_mem_req_ready), 64'(acc && g == 1));
        chk("mem_req_addr", 64'(mem_req_addr), 64'(eaddr));
        chk("mem_req_rw", 64'(mem_req_rw), 64'(gp && dc_mem_req_rw));
        chk("mem_req_tag", 64'(mem_req_tag), 64'(etag));
        chk("ic_resp_valid", 64'(ic_mem_resp_valid), 64'(rok && rp == 0));
        chk("dc_resp_valid", 64'(dc_mem_resp_valid), 64'(rok && rp == 1));
        chk("ic_outstanding", 64'(ic_outstanding), 64'(cnt[0]));
        chk("dc_outstanding", 64'(dc_outstanding), 64'(cnt[1]));
        chk("tag_err", 64'(tag_err), 64'(err));

        o_tag = mem_req_tag; o_valid = mem_req_valid;
        o_ic_rdy = ic_mem_req_ready; o_dc_rdy = dc_mem_req_ready;
        o_ic_resp = ic_mem_resp_valid; o_dc_resp = dc_mem_resp_valid;
        o_err = tag_err; o_ic_out = ic_outstanding;

        @(posedge clk);
        acc_p[0] = 1'b0; acc_p[1] = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else begin
            if (viol) err = 1'b1;
            if (rhit && (cnt[rp] == 0 || rs != 3'(exps[rp]))) err = 1'b1;
            if (rok) begin cnt[rp]--; exps[rp]++; end
            if (acc) begin
                cnt[g]++; iss[g]++; last = g; lk = -1; acc_p[g] = 1'b1;
            end else if (g >= 0) begin
                lk = g;
            end else begin
                lk = -1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ic_mem_req_valid = 1'b0; dc_mem_req_valid = 1'b0; dc_mem_req_rw = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = 4'd0;
    endtask

    // Reset with busy inputs so gating of every output is exercised.
    task automatic do_reset();
        reset_n = 1'b0;
        ic_mem_req_valid = 1'b1; dc_mem_req_valid = 1'b1; dc_mem_req_rw = 1'b1;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_tag = 4'h1;
        step();
        step();
        reset_n = 1'b1;
        idle_inputs();
    endtask

    task automatic set_resp(input bit v, input logic [3:0] t);
        mem_resp_valid = v; mem_resp_tag = t;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        #1;
        do_reset();
        chk("rst_valid", 64'(o_valid), 64'd0);

        // 1: both valid, memory always ready -> alternating grants
        ic_mem_req_valid = 1'b1; dc_mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        ic_mem_req_addr = $urandom; dc_mem_req_addr = $urandom;
        for (int i = 0; i < 4; i++) begin
            step();
            t1_tags[i] = o_tag;
            if (acc_p[0]) ic_mem_req_addr = $urandom;
            if (acc_p[1]) dc_mem_req_addr = $urandom;
        end
        for (int i = 0; i < 4; i++) chk("t1_tag", 64'(t1_tags[i]), 64'(i));

        // 2: grant lock on D$ while memory stalls
        do_reset();
        dc_mem_req_valid = 1'b1; dc_mem_req_addr = 32'h0000_1000;
        step();
        ic_mem_req_valid = 1'b1; ic_mem_req_addr = 32'h0000_2000;
        step();
        step();
        chk("t2_locked_dc", 64'(o_tag[0]), 64'd1);
        mem_req_ready = 1'b1;
        step();
        chk("t2_dc_accept", 64'(o_dc_rdy), 64'd1);
        dc_mem_req_valid = 1'b0;
        step();
        chk("t2_ic_accept", 64'(o_ic_rdy), 64'd1);
        idle_inputs();

        // 3: I$ credit exhaustion and resume
        do_reset();
        ic_mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ic_mem_req_addr = $urandom;
            step();
        end
        dc_mem_req_valid = 1'b1;
        step();
        chk("t3_dc_served", 64'(o_dc_rdy), 64'd1);
        dc_mem_req_valid = 1'b0;
        step();
        chk("t3_ic_blocked", 64'(o_valid), 64'd0);
        set_resp(1'b1, 4'h0);
        step();
        chk("t3_ic_resp", 64'(o_ic_resp), 64'd1);
        set_resp(1'b0, 4'h0);
        step();
        chk("t3_ic_resume", 64'(o_ic_rdy), 64'd1);
        idle_inputs();

        // 4: out-of-order D$ responses
        do_reset();
        dc_mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        step();
        step();
        dc_mem_req_valid = 1'b0;
        set_resp(1'b1, 4'h3);
        step();
        chk("t4_resp3", 64'(o_dc_resp), 64'd1);
        set_resp(1'b1, 4'h1);
        step();
        chk("t4_resp1", 64'(o_dc_resp), 64'd1);
        chk("t4_err_set", 64'(o_err), 64'd1);
        set_resp(1'b0, 4'h0);
        step();
        step();
        chk("t4_err_sticky", 64'(o_err), 64'd1);

        // 5: accept + response same cycle, sequence wrap
        do_reset();
        ic_mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) set_resp(1'b1, resp_tag_for(0));
            else set_resp(1'b0, 4'h0);
            ic_mem_req_addr = $urandom;
            step();
            t5_tags[i] = o_tag;
        end
        idle_inputs();
        step();
        chk("t5_count", 64'(o_ic_out), 64'd2);
        chk("t5_tag_e", 64'(t5_tags[7]), 64'hE);
        chk("t5_tag_wrap", 64'(t5_tags[8]), 64'h0);

        // 6: reset while locked on I$ with 3 in flight
        do_reset();
        ic_mem_req_valid = 1'b1; mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        mem_req_ready = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        chk("t6_rst_count", 64'(o_ic_out), 64'd0);
        chk("t6_rst_valid", 64'(o_valid), 64'd0);
        reset_n = 1'b1;
        idle_inputs();
        set_resp(1'b1, 4'h0);
        step();
        chk("t6_no_forward", 64'(o_ic_resp), 64'd0);
        set_resp(1'b0, 4'h0);
        step();
        chk("t6_err", 64'(o_err), 64'd1);

        // protocol violation: locked port drops valid
        do_reset();
        dc_mem_req_valid = 1'b1;
        step();
        dc_mem_req_valid = 1'b0;
        step();
        chk("viol_no_xfer", 64'(o_valid), 64'd0);
        step();
        chk("viol_err", 64'(o_err), 64'd1);

        // randomized traffic with legal request handshakes
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                do_reset();
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            if (acc_p[0] || !ic_mem_req_valid) begin
                ic_mem_req_valid = 1'($urandom_range(0, 1));
                ic_mem_req_addr = $urandom;
            end
            if (acc_p[1] || !dc_mem_req_valid) begin
                dc_mem_req_valid = 1'($urandom_range(0, 1));
                dc_mem_req_addr = $urandom;
                dc_mem_req_rw = 1'($urandom_range(0, 1));
            end
            begin
                int p;
                p = int'($urandom_range(0, 1));
                set_resp(1'b0, 4'h0);
                if (cnt[p] > 0 && $urandom_range(0, 2) == 0) begin
                    set_resp(1'b1, resp_tag_for(p));
                    if ($urandom_range(0, 19) == 0) mem_resp_tag = mem_resp_tag ^ 4'b0010;
                end else if ($urandom_range(0, 49) == 0) begin
                    set_resp(1'b1, 4'($urandom_range(0, 15)));
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
